// File: rtl/upsample_pkg.sv
// rtl/upsample_pkg.sv - shared FSM state type and default timing constants for upsample_scheduler
package upsample_pkg;

  localparam int DEF_CYCLES_PER_SAMPLE = 2272;
  localparam int DEF_UPSAMPLE_FACTOR   = 16;
  localparam int DEF_CYCLES_PER_SUB    = DEF_CYCLES_PER_SAMPLE / DEF_UPSAMPLE_FACTOR;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous sample FIFO with flush and occupancy output
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             empty, full, push_ok, pop_ok;

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_W'(DEPTH));
    pop_ok   = pop && !empty;
    // a pop frees the slot the push lands in, so a full FIFO still accepts
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/upsample_scheduler.sv
// rtl/upsample_scheduler.sv - paces FIFO'd synth samples out at one strobe per base period
// Optional underrun statistics counter enabled by defining UPSAMPLE_SCHED_STATS_EN.
module upsample_scheduler
  import upsample_pkg::*;
#(
  parameter int CYCLES_PER_SAMPLE = DEF_CYCLES_PER_SAMPLE,
  parameter int UPSAMPLE_FACTOR   = DEF_UPSAMPLE_FACTOR,
  parameter int FIFO_DEPTH        = 4,
  parameter int PRIME_LEVEL       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [15:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [15:0]                   sample_out,
  output logic                          sample_out_valid,
  output logic [3:0]                    phase_index,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_count,
  output logic                          running
);

  localparam int SUB_CYCLES = CYCLES_PER_SAMPLE / UPSAMPLE_FACTOR;
  localparam int BASE_W     = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;
  localparam int SUB_W      = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BASE_W-1:0] BASE_LAST  = BASE_W'(CYCLES_PER_SAMPLE - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(SUB_CYCLES - 1);
  localparam logic [3:0]        PHASE_LAST = 4'(UPSAMPLE_FACTOR - 1);
  localparam logic [LVL_W-1:0]  PRIME_LVL  = LVL_W'(PRIME_LEVEL);
  localparam logic [LVL_W-1:0]  FULL_LVL   = LVL_W'(FIFO_DEPTH);

  sched_state_e      state_q, state_d;
  logic [BASE_W-1:0] base_cnt_q, base_cnt_d;
  logic [SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
  logic [3:0]        phase_q, phase_d;
  logic              strobe_q, strobe_d;
  logic [15:0]       sample_out_q, sample_out_d;
  logic              run_now, run_next, push, pop;
  logic [15:0]       fifo_head;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_PRIME;
      ST_PRIME: if (fifo_level >= PRIME_LVL) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
  end

  // Strobe, pop and the new sample are all decided one cycle ahead and
  // registered together, so the popped value lands on sample_out with its strobe.
  always_comb begin
    run_now    = (state_q == ST_RUN);
    run_next   = (state_d == ST_RUN);
    base_cnt_d = '0;
    if (run_next && run_now) begin
      base_cnt_d = (base_cnt_q == BASE_LAST) ? '0 : base_cnt_q + 1'b1;
    end
    strobe_d  = run_next && (base_cnt_d == '0);
    sub_cnt_d = (!run_next || strobe_d || sub_cnt_q == SUB_LAST) ? '0 : sub_cnt_q + 1'b1;
    phase_d   = phase_q;
    if (!run_next || strobe_d) begin
      phase_d = '0;
    end else if (sub_cnt_q == SUB_LAST) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
    end
    pop          = strobe_d && (fifo_level != '0);
    sample_out_d = sample_out_q;
    if (!run_next) begin
      sample_out_d = '0;
    end else if (pop) begin
      sample_out_d = fifo_head;
    end
    s_ready = (state_q != ST_IDLE) && (fifo_level < FULL_LVL);
    push    = s_valid && s_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      base_cnt_q   <= '0;
      sub_cnt_q    <= '0;
      phase_q      <= '0;
      strobe_q     <= 1'b0;
      sample_out_q <= '0;
    end else begin
      state_q      <= state_d;
      base_cnt_q   <= base_cnt_d;
      sub_cnt_q    <= sub_cnt_d;
      phase_q      <= phase_d;
      strobe_q     <= strobe_d;
      sample_out_q <= sample_out_d;
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (!enable),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (fifo_head),
    .level     (fifo_level)
  );

`ifdef UPSAMPLE_SCHED_STATS_EN
  logic [15:0] underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (strobe_d && (fifo_level == '0) && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_q <= '0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun_count = underrun_q;
`else
  assign underrun_count = 16'h0000;
`endif

  assign sample_out       = sample_out_q;
  assign sample_out_valid = strobe_q;
  assign phase_index      = phase_q;
  assign running          = run_now;

endmodule

// File: tb/tb_upsample_scheduler.sv
// tb/tb_upsample_scheduler.sv - randomized and directed bench for upsample_scheduler against a queue-based model
module tb_upsample_scheduler;

  localparam int CPS   = 2272;
  localparam int SUB   = 142;
  localparam int DEPTH = 4;
  localparam int PRIME = 2;

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic [3:0]  phase_index;
  logic [2:0]  fifo_level;
  logic [15:0] underrun_count;
  logic        running;

  always #5 clk = ~clk;

  upsample_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .phase_index      (phase_index),
    .fifo_level       (fifo_level),
    .underrun_count   (underrun_count),
    .running          (running)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: mode, cycles spent in RUN, and a plain sample queue.
  int          m_mode   = M_IDLE;
  int          m_t      = 0;
  logic [15:0] m_q[$];
  logic [15:0] m_out    = 16'h0;
  bit          m_strobe = 1'b0;
  int          m_und    = 0;

  function automatic int exp_underruns();
`ifdef UPSAMPLE_SCHED_STATS_EN
    return m_und;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    int nm;
    if (rst) begin
      m_mode = M_IDLE; m_t = 0; m_q.delete(); m_out = 16'h0; m_strobe = 1'b0; m_und = 0;
    end else begin
      acc = s_valid && (m_mode != M_IDLE) && (m_q.size() < DEPTH);
      nm  = m_mode;
      if (!enable) nm = M_IDLE;
      else if (m_mode == M_IDLE) nm = M_PRIME;
      else if (m_mode == M_PRIME && m_q.size() >= PRIME) nm = M_RUN;
      if (nm == M_RUN) begin
        m_t      = (m_mode == M_RUN) ? m_t + 1 : 0;
        m_strobe = ((m_t % CPS) == 0);
      end else begin
        m_t = 0; m_strobe = 1'b0; m_out = 16'h0;
      end
      if (m_strobe) begin
        if (m_q.size() > 0) m_out = m_q.pop_front();
        else if (m_und < 65535) m_und++;
      end
      if (acc) m_q.push_back(s_data);
      if (!enable) m_q.delete();
      m_mode = nm;
    end
  end

  always @(negedge clk) begin
    check("sample_out", sample_out, m_out);
    check("valid", sample_out_valid, m_strobe);
    check("phase", phase_index, (m_mode == M_RUN) ? (m_t % CPS) / SUB : 0);
    check("level", fifo_level, m_q.size());
    check("underrun", underrun_count, exp_underruns());
    check("running", running, m_mode == M_RUN);
    check("s_ready", s_ready, (m_mode != M_IDLE) && (m_q.size() < DEPTH));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_strobe(input int budget, output int waited);
    waited = 0;
    while (sample_out_valid !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check("strobe_seen", sample_out_valid, 1);
  endtask

  task automatic push_one(input logic [15:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic count_strobes(input int n, output int strobes);
    strobes = 0;
    repeat (n) begin
      @(negedge clk);
      if (sample_out_valid === 1'b1) strobes++;
    end
  endtask

  initial begin
    int          w;
    int          cnt;
    int          max_ph;
    int          mode;
    logic [15:0] d0;

    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = 16'h0;
    repeat (3) tick();
    check("rst_running", running, 0);
    check("rst_ready", s_ready, 0);
    check("rst_level", fifo_level, 0);

    // Prime with two samples, first strobe carries the first one
    rst = 1'b0; enable = 1'b1;
    tick();
    s_valid = 1'b1; s_data = 16'h1111; tick();
    s_data = 16'h2222; tick();
    s_valid = 1'b0;
    wait_strobe(10, w);
    check("first_data", sample_out, 16'h1111);
    check("running_rises", running, 1);
    tick();
    wait_strobe(CPS + 10, w);
    check("period", w + 1, CPS);
    check("second_data", sample_out, 16'h2222);

    // Starved: strobes keep repeating the last sample and count underruns
    tick();
    wait_strobe(CPS + 10, w);
    check("ur1_data", sample_out, 16'h2222);
`ifdef UPSAMPLE_SCHED_STATS_EN
    check("ur1_count", underrun_count, 1);
`else
    check("ur1_count", underrun_count, 0);
`endif
    check("phase_at_strobe", phase_index, 0);
    max_ph = 0;
    for (int i = 1; i < CPS; i++) begin
      tick();
      if (i == SUB) check("phase_step", phase_index, 1);
      if (int'(phase_index) > max_ph) max_ph = int'(phase_index);
    end
    check("phase_max", max_ph, 15);
    tick();
    check("phase_wrap_strobe", sample_out_valid, 1);
    check("phase_wrap", phase_index, 0);
    check("ur2_data", sample_out, 16'h2222);
`ifdef UPSAMPLE_SCHED_STATS_EN
    check("ur2_count", underrun_count, 2);
`else
    check("ur2_count", underrun_count, 0);
`endif

    // Back-pressure: keep s_valid high until the FIFO fills
    s_valid = 1'b1;
    repeat (20) begin
      s_data = 16'($urandom);
      tick();
    end
    check("full_level", fifo_level, 4);
    check("full_ready", s_ready, 0);
    w = 0;
    while (sample_out_valid !== 1'b1 && w < CPS + 10) begin
      s_data = 16'($urandom);
      tick();
      w++;
    end
    check("strobe_seen_full", sample_out_valid, 1);
    check("ready_at_strobe", s_ready, 1);
    tick();
    check("level_after_coincident", fifo_level, 4);
    s_valid = 1'b0;

    // Drop enable mid-period
    repeat (500) tick();
    enable = 1'b0;
    tick();
    check("dis_running", running, 0);
    check("dis_level", fifo_level, 0);
    check("dis_out", sample_out, 0);
    check("dis_valid", sample_out_valid, 0);
    enable = 1'b1;
    count_strobes(3000, cnt);
    check("dis_no_strobe", cnt, 0);
    push_one(16'hA5A5);
    repeat (50) tick();
    check("one_push_not_running", running, 0);
    push_one(16'h5A5A);
    wait_strobe(10, w);
    check("reenable_data", sample_out, 16'hA5A5);

    // Reset pulse 100 cycles after a strobe
    tick();
    wait_strobe(CPS + 10, w);
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_running", running, 0);
    check("rst2_valid", sample_out_valid, 0);
    check("rst2_out", sample_out, 0);
    check("rst2_level", fifo_level, 0);
    check("rst2_underrun", underrun_count, 0);
    count_strobes(500, cnt);
    check("rst2_no_strobe", cnt, 0);
    d0 = 16'($urandom);
    push_one(d0);
    push_one(16'($urandom));
    wait_strobe(10, w);
    check("rst2_first_data", sample_out, d0);

    // Randomized traffic: dense, sparse or no pushes per period, rare enable drops
    for (int p = 0; p < 4; p++) begin
      mode = $urandom_range(0, 2);
      for (int c = 0; c < CPS; c++) begin
        case (mode)
          0:       s_valid = 1'($urandom_range(0, 1));
          1:       s_valid = ($urandom_range(0, 1499) == 0);
          default: s_valid = 1'b0;
        endcase
        s_data = 16'($urandom);
        enable = ($urandom_range(0, 2999) != 0);
        tick();
      end
    end
    s_valid = 1'b0;
    enable  = 1'b1;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
